mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
MEM stage of the RV32I_X pipeline. It consumes the EXE→MEM bundle (opcode, rd, result, memory address, store data) and performs loads and stores on a req/gnt/rvalid data-memory port, with byte-lane steering and load sign/zero extension. It forwards non-memory results, stalls EXE while an access is outstanding, and flags misaligned and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 64, cycles waited in REQ or WAIT before the access is abandoned with bus_err_o
OPC_W, 32, opcode width; codes LH=0 LB=1 LW=2 LBU=3 LHU=4 SW=5 SH=6 SB=7, all other codes are non-memory

Ports:
clk  in  1  clock
rstl  in  1  reset
valid_exe_2_mem_i  in  1  EXE bundle valid
ready_mem_2_exe_o  out  1  MEM can accept a bundle
opcode_exe_2_mem_i  in  OPC_W  operation type
rd_exe_2_mem_i  in  11  destination register number
rd_data_exe_2_mem_i  in  32  EXE result (non-memory ops)
mem_address_i  in  32  byte address for load/store
mem_data_i  in  32  store data (low bits significant)
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1=store
dmem_addr_o  out  32  word address {addr[31:2],2'b00}
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  32  load word
wb_valid_o  out  1  writeback bundle valid, 1-cycle pulse
wb_we_o  out  1  write rd
rd_mem_2_wb_o  out  11  destination register
rd_data_mem_2_wb_o  out  32  writeback data
misalign_o  out  1  1-cycle pulse, misaligned access dropped
bus_err_o  out  1  1-cycle pulse, access timed out

Behaviour:
- Interface: one clock clk; reset rstl is synchronous and active-high.
- Reset: state IDLE, timeout counter 0, every output 0 except ready_mem_2_exe_o=1.
- ready_mem_2_exe_o = (state==IDLE). A bundle is accepted on a clk edge where valid && ready.
- States: IDLE, REQ, WAIT.
- IDLE, non-memory op accepted: next cycle wb_valid_o=1, wb_we_o=(rd!=0), rd and data passed through; stay IDLE (1-cycle latency, back-to-back allowed).
- IDLE, memory op accepted: check alignment. LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. If misaligned: next cycle misalign_o=1 and wb_valid_o=0, no memory access, stay IDLE. If aligned: latch opcode, rd, addr[1:0], be and wdata, then go to REQ.
- REQ: dmem_req_o=1, with we, addr, be and wdata held stable until gnt.
  - Store with gnt: wb_valid_o=1, wb_we_o=0 the next cycle; go to IDLE.
  - Load with gnt: go to WAIT. A load has at most one outstanding request.
- WAIT: dmem_req_o=0. On rvalid, extract the lane and go to IDLE; the next cycle wb_valid_o=1, wb_we_o=(rd!=0).
- Lanes: SB be=1<<addr[1:0], wdata={4{d[7:0]}}. SH be=addr[1]?1100:0011, wdata={2{d[15:0]}}. SW be=1111.
- Load extraction: byte=rdata[8*addr[1:0]+:8], half=rdata[16*addr[1]+:16]. LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word.
- Timeout: counter clears on entry to REQ and on REQ→WAIT, and increments each cycle in REQ or WAIT. Reaching TIMEOUT_CYCLES-1 without the awaited gnt/rvalid gives bus_err_o=1 the next cycle, no writeback, and a return to IDLE.
- rvalid outside WAIT and gnt outside REQ are ignored.
- Reset mid-access: dmem_req_o drops the cycle after reset; a later rvalid is ignored.
- wb_valid_o, misalign_o and bus_err_o are mutually exclusive, and each pulses for exactly one cycle per accepted bundle.

Test Plan:
- Reset, then ADD bundle rd=5 data=0x1234 → one cycle later wb_valid_o=1, wb_we_o=1, rd=5, data=0x00001234; ready stays 1. Repeat with rd=0 → wb_we_o=0.
- LB addr=0x1003, gnt on the first REQ cycle, rvalid next cycle with rdata=0x80FF_FFFF → wb data 0xFFFFFF80 three cycles after accept. LBU same stimulus → 0x00000080.
- SH addr=0x2002 data=0xABCD1234, gnt delayed 3 cycles → dmem_addr_o=0x2000, be=1100, wdata=0x12341234 held stable for all REQ cycles; ready_mem_2_exe_o=0 until the cycle after gnt; wb_we_o=0.
- LW addr=0x3001 → misalign_o pulse, dmem_req_o never asserts. Next bundle SW addr=0x3004 is accepted normally.
- LH with gnt but no rvalid, TIMEOUT_CYCLES=8 → bus_err_o pulse after 8 WAIT cycles, return to IDLE. A subsequent stray rvalid is ignored (no wb_valid_o).
- Assert rstl during WAIT of an LW → all outputs at reset values the next cycle; rvalid delivered afterwards produces no writeback.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM stage: load/store unit on a req/gnt/rvalid data port.
// Lane steering, load extension, misalign and timeout reporting.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int OPC_W          = 32
) (
  input  logic             clk,
  input  logic             rstl,
  input  logic             valid_exe_2_mem_i,
  output logic             ready_mem_2_exe_o,
  input  logic [OPC_W-1:0] opcode_exe_2_mem_i,
  input  logic [10:0]      rd_exe_2_mem_i,
  input  logic [31:0]      rd_data_exe_2_mem_i,
  input  logic [31:0]      mem_address_i,
  input  logic [31:0]      mem_data_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [31:0]      dmem_addr_o,
  output logic [3:0]       dmem_be_o,
  output logic [31:0]      dmem_wdata_o,
  input  logic             dmem_gnt_i,
  input  logic             dmem_rvalid_i,
  input  logic [31:0]      dmem_rdata_i,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [10:0]      rd_mem_2_wb_o,
  output logic [31:0]      rd_data_mem_2_wb_o,
  output logic             misalign_o,
  output logic             bus_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [OPC_W-1:0] OP_LH  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LB  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LW  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LBU = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_LHU = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SW  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SH  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SB  = OPC_W'(7);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [OPC_W-1:0] op_q;
  logic [10:0]      rd_q;
  logic [1:0]       a_q;
  logic             is_ld, is_st, is_half, is_word;
  logic             is_mem, misal, accept, tmo;
  logic [3:0]       be_n;
  logic [31:0]      wdata_n;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic [31:0]      ld_data;

  assign ready_mem_2_exe_o = (state == IDLE);
  assign dmem_req_o        = (state == REQ);
  assign accept  = valid_exe_2_mem_i && (state == IDLE);
  assign is_mem  = is_ld | is_st;
  assign misal   = (is_half & mem_address_i[0])
                 | (is_word & |mem_address_i[1:0]);
  assign tmo     = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Opcode decode and store lane steering
  always_comb begin
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    be_n    = 4'b1111;
    wdata_n = mem_data_i;
    case (opcode_exe_2_mem_i)
      OP_LH, OP_LHU: begin
        is_ld   = 1'b1;
        is_half = 1'b1;
      end
      OP_LB, OP_LBU: is_ld = 1'b1;
      OP_LW: begin
        is_ld   = 1'b1;
        is_word = 1'b1;
      end
      OP_SW: begin
        is_st   = 1'b1;
        is_word = 1'b1;
      end
      OP_SH: begin
        is_st   = 1'b1;
        is_half = 1'b1;
        be_n    = mem_address_i[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{mem_data_i[15:0]}};
      end
      OP_SB: begin
        is_st   = 1'b1;
        be_n    = 4'b0001 << mem_address_i[1:0];
        wdata_n = {4{mem_data_i[7:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    ld_b = dmem_rdata_i[{a_q, 3'b000} +: 8];
    ld_h = dmem_rdata_i[{a_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
      OP_LBU:  ld_data = {24'd0, ld_b};
      OP_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
      OP_LHU:  ld_data = {16'd0, ld_h};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mem && !misal) state_next = REQ;
      REQ: begin
        if (dmem_gnt_i) state_next = dmem_we_o ? IDLE : WAIT;
        else if (tmo)   state_next = IDLE;
      end
      WAIT: if (dmem_rvalid_i || tmo) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rstl) state <= IDLE;
    else      state <= state_next;
  end

  // Request latch, timeout counter and writeback pulses
  always_ff @(posedge clk) begin
    if (rstl) begin
      cnt                <= '0;
      op_q               <= '0;
      rd_q               <= '0;
      a_q                <= '0;
      dmem_we_o          <= 1'b0;
      dmem_addr_o        <= '0;
      dmem_be_o          <= '0;
      dmem_wdata_o       <= '0;
      wb_valid_o         <= 1'b0;
      wb_we_o            <= 1'b0;
      rd_mem_2_wb_o      <= '0;
      rd_data_mem_2_wb_o <= '0;
      misalign_o         <= 1'b0;
      bus_err_o          <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (!is_mem) begin
            wb_valid_o         <= 1'b1;
            wb_we_o            <= (rd_exe_2_mem_i != 11'd0);
            rd_mem_2_wb_o      <= rd_exe_2_mem_i;
            rd_data_mem_2_wb_o <= rd_data_exe_2_mem_i;
          end else if (misal) begin
            misalign_o <= 1'b1;
          end else begin
            cnt          <= '0;
            op_q         <= opcode_exe_2_mem_i;
            rd_q         <= rd_exe_2_mem_i;
            a_q          <= mem_address_i[1:0];
            dmem_we_o    <= is_st;
            dmem_addr_o  <= {mem_address_i[31:2], 2'b00};
            dmem_be_o    <= be_n;
            dmem_wdata_o <= wdata_n;
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            cnt <= '0;
            if (dmem_we_o) begin
              wb_valid_o         <= 1'b1;
              wb_we_o            <= 1'b0;
              rd_mem_2_wb_o      <= rd_q;
              rd_data_mem_2_wb_o <= '0;
            end
          end else if (tmo) begin
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            wb_valid_o         <= 1'b1;
            wb_we_o            <= (rd_q != 11'd0);
            rd_mem_2_wb_o      <= rd_q;
            rd_data_mem_2_wb_o <= ld_data;
          end else if (tmo) begin
            bus_err_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized scoreboard bench for mem_lsu.
// Byte-array reference memory predicts every writeback.
module tb_mem_lsu;

  localparam int T = 8;

  localparam logic [31:0] LH  = 32'd0;
  localparam logic [31:0] LB  = 32'd1;
  localparam logic [31:0] LW  = 32'd2;
  localparam logic [31:0] LBU = 32'd3;
  localparam logic [31:0] LHU = 32'd4;
  localparam logic [31:0] SW  = 32'd5;
  localparam logic [31:0] SH  = 32'd6;
  localparam logic [31:0] SB  = 32'd7;
  localparam logic [31:0] ADD = 32'd20;

  logic        clk = 1'b0;
  logic        rstl = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] opcode = '0;
  logic [10:0] rd = '0;
  logic [31:0] rd_data = '0;
  logic [31:0] maddr = '0;
  logic [31:0] mdata = '0;
  logic        req, we;
  logic [31:0] daddr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        wb_valid, wb_we;
  logic [10:0] wb_rd;
  logic [31:0] wb_data;
  logic        misalign, bus_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          kind;
    logic        we;
    logic [10:0] rd;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem[64];
  logic [31:0] dev[16];

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(T), .OPC_W(32)) dut (
    .clk(clk),
    .rstl(rstl),
    .valid_exe_2_mem_i(valid),
    .ready_mem_2_exe_o(ready),
    .opcode_exe_2_mem_i(opcode),
    .rd_exe_2_mem_i(rd),
    .rd_data_exe_2_mem_i(rd_data),
    .mem_address_i(maddr),
    .mem_data_i(mdata),
    .dmem_req_o(req),
    .dmem_we_o(we),
    .dmem_addr_o(daddr),
    .dmem_be_o(be),
    .dmem_wdata_o(wdata),
    .dmem_gnt_i(gnt),
    .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata),
    .wb_valid_o(wb_valid),
    .wb_we_o(wb_we),
    .rd_mem_2_wb_o(wb_rd),
    .rd_data_mem_2_wb_o(wb_data),
    .misalign_o(misalign),
    .bus_err_o(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [31:0] op);
    if (op == LW || op == SW) return 4;
    if (op == LH || op == LHU || op == SH) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] op,
                                           input logic [31:0] a);
    int b = int'(a[5:0]);
    logic [31:0] w = '0;
    for (int i = 0; i < nbytes(op); i++) w[8*i +: 8] = ref_mem[b + i];
    if (op == LB) return {{24{w[7]}}, w[7:0]};
    if (op == LH) return {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] op, input logic [31:0] a,
                           input logic [31:0] d);
    int b = int'(a[5:0]);
    for (int i = 0; i < nbytes(op); i++) ref_mem[b + i] = d[8*i +: 8];
  endtask

  // Monitor: pops one expectation per output pulse
  always @(negedge clk) begin
    if (!rstl && (wb_valid || misalign || bus_err)) begin
      exp_t e;
      int k;
      chk("exclusive", $countones({wb_valid, misalign, bus_err}), 1);
      k = wb_valid ? 0 : (misalign ? 1 : 2);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected: pulse kind %0d with empty queue", k);
      end else begin
        e = sbq.pop_front();
        chk("kind", k, e.kind);
        if (e.kind == 0 && k == 0) begin
          chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
          if (e.chk_data) begin
            chk("wb_rd", {21'd0, wb_rd}, {21'd0, e.rd});
            chk("wb_data", wb_data, e.data);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) chk("ready_wait", 0, 1);
  endtask

  task automatic req_stable(input logic [31:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic st);
    chk("req", {31'd0, req}, 1);
    chk("rdy_busy", {31'd0, ready}, 0);
    chk("we", {31'd0, we}, {31'd0, st});
    chk("daddr", daddr, {a[31:2], 2'b00});
    if (op == SB) begin
      chk("be", {28'd0, be}, {28'd0, 4'b0001 << a[1:0]});
      chk("wdata", wdata, {4{d[7:0]}});
    end else if (op == SH) begin
      chk("be", {28'd0, be}, a[1] ? 32'hC : 32'h3);
      chk("wdata", wdata, {2{d[15:0]}});
    end else if (op == SW) begin
      chk("be", {28'd0, be}, 32'hF);
      chk("wdata", wdata, d);
    end
  endtask

  // Issue one bundle at a negedge and play the memory side; ends at a negedge.
  // hang: 0 normal, 1 never grant, 2 grant but never rvalid
  task automatic do_op(input logic [31:0] op, input logic [10:0] r,
                       input logic [31:0] rdat, input logic [31:0] a,
                       input logic [31:0] d, input int gd, input int rdl,
                       input int hang);
    exp_t e;
    bit ld, st, mis;
    logic [31:0] word;
    int n;
    ld  = (op <= 32'd4);
    st  = (op >= 32'd5 && op <= 32'd7);
    mis = ((op == LH || op == LHU || op == SH) && a[0]) ||
          ((op == LW || op == SW) && a[1:0] != 2'b00);
    wait_ready();
    e.rd = r;
    e.data = rdat;
    e.we = (r != 0);
    e.chk_data = 1'b1;
    e.kind = 0;
    if ((ld || st) && mis) e.kind = 1;
    else if ((ld || st) && hang != 0) e.kind = 2;
    else if (st) begin
      e.we = 1'b0;
      e.chk_data = 1'b0;
      ref_store(op, a, d);
    end else if (ld) e.data = ref_load(op, a);
    sbq.push_back(e);
    valid = 1'b1;
    opcode = op;
    rd = r;
    rd_data = rdat;
    maddr = a;
    mdata = d;
    @(negedge clk);
    valid = 1'b0;
    if (!(ld || st)) return;
    if (mis) begin
      chk("mis_noreq", {31'd0, req}, 0);
      @(negedge clk);
      chk("mis_noreq2", {31'd0, req}, 0);
      return;
    end
    if (hang == 1) begin
      n = 0;
      while (!bus_err && n < T + 4) begin
        @(negedge clk);
        n++;
      end
      chk("req_tmo_len", n, T);
      return;
    end
    for (int i = 0; i < gd; i++) begin
      req_stable(op, a, d, st);
      @(negedge clk);
    end
    req_stable(op, a, d, st);
    gnt = 1'b1;
    if (st) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) dev[daddr[5:2]][8*b +: 8] = wdata[8*b +: 8];
    end
    word = dev[daddr[5:2]];
    @(negedge clk);
    gnt = 1'b0;
    if (st) begin
      chk("rdy_after_gnt", {31'd0, ready}, 1);
      return;
    end
    if (hang == 2) begin
      n = 1;
      while (!bus_err && n < T + 5) begin
        @(negedge clk);
        n++;
      end
      chk("wait_tmo_len", n, T + 1);
      chk("rdy_after_err", {31'd0, ready}, {31'd0, bus_err});
      rvalid = 1'b1;
      rdata = $urandom;
      @(negedge clk);
      rvalid = 1'b0;
      return;
    end
    chk("wait_noreq", {31'd0, req}, 0);
    repeat (rdl) @(negedge clk);
    rvalid = 1'b1;
    rdata = word;
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, {31'd0, ready}, 1);
    chk({tag, "_req"}, {31'd0, req}, 0);
    chk({tag, "_we"}, {31'd0, we}, 0);
    chk({tag, "_daddr"}, daddr, 0);
    chk({tag, "_be"}, {28'd0, be}, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 0);
    chk({tag, "_wbwe"}, {31'd0, wb_we}, 0);
    chk({tag, "_wbrd"}, {21'd0, wb_rd}, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_mis"}, {31'd0, misalign}, 0);
    chk({tag, "_err"}, {31'd0, bus_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] op, a;
    int hg;
    for (int i = 0; i < 16; i++) begin
      dev[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = dev[i][8*b +: 8];
    end
    dev[0] = 32'h80FF_FFFF;
    for (int b = 0; b < 4; b++) ref_mem[b] = dev[0][8*b +: 8];

    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rstl = 1'b0;
    @(negedge clk);

    do_op(ADD, 11'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 0);
    chk("rdy_add", {31'd0, ready}, 1);
    do_op(ADD, 11'd0, 32'h5678, 32'h0, 32'h0, 0, 0, 0);
    do_op(LB, 11'd3, 32'h0, 32'h1003, 32'h0, 0, 0, 0);
    do_op(LBU, 11'd4, 32'h0, 32'h1003, 32'h0, 0, 0, 0);
    do_op(SH, 11'd6, 32'h0, 32'h2002, 32'hABCD_1234, 3, 0, 0);
    do_op(LW, 11'd7, 32'h0, 32'h3001, 32'h0, 0, 0, 0);
    do_op(SW, 11'd8, 32'h0, 32'h3004, 32'hCAFE_F00D, 1, 0, 0);
    do_op(LH, 11'd9, 32'h0, 32'h4000, 32'h0, 0, 0, 2);
    repeat (3) @(negedge clk);

    // Reset in the middle of an LW, then a late rvalid
    valid = 1'b1;
    opcode = LW;
    rd = 11'd10;
    maddr = 32'h0000_5008;
    @(negedge clk);
    valid = 1'b0;
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rstl = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rstl = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h1111_2222;
    @(negedge clk);
    rvalid = 1'b0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 150; k++) begin
      op = 32'($urandom_range(0, 9));
      if (op > 7) op = 32'd8 + 32'($urandom_range(0, 1 << 20));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      hg = 0;
      if ($urandom_range(0, 15) == 0) hg = (op <= 32'd4) ? 2 : 1;
      if ($urandom_range(0, 31) == 0 && op <= 32'd7) hg = 1;
      do_op(op, 11'($urandom_range(0, 3)), $urandom, a, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), hg);
    end

    for (int i = 0; i < 16; i++)
      do_op(LW, 11'd1, 32'h0, 32'(4 * i), 32'h0, $urandom_range(0, 1),
            $urandom_range(0, 2), 0);

    repeat (6) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
